// File: rtl/cla_seq_adder.sv
// Nibble-serial WIDTH-bit add/subtract built on one shared 4-bit CLA slice, with a start/done handshake.
// Optional signed-overflow and zero flags are enabled with the CLA_SEQ_FLAGS_EN macro.

module cla_4 (
    input  logic [3:0] x,
    input  logic [3:0] y,
    input  logic       cin,
    output logic [3:0] s,
    output logic       cout
);
    logic [3:0] p;
    logic [3:0] g;
    logic [4:0] c;

    assign p = x ^ y;
    assign g = x & y;

    // Carries are fully expanded so no carry waits on a lower one.
    assign c[0] = cin;
    assign c[1] = g[0] | (p[0] & cin);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & cin);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & cin);

    assign s    = p ^ c[3:0];
    assign cout = c[4];
endmodule

module cla_seq_adder #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout
`ifdef CLA_SEQ_FLAGS_EN
    ,
    output logic             overflow,
    output logic             zero
`endif
);
    localparam int NIB  = WIDTH / 4;
    localparam int IDXW = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NIB - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  opa_q, opa_d;
    logic [WIDTH-1:0]  opb_q, opb_d;
    logic [WIDTH-1:0]  result_q, result_d;
    logic              carry_q, carry_d;
    logic              cout_q, cout_d;
    logic [IDXW-1:0]   idx_q, idx_d;
`ifdef CLA_SEQ_FLAGS_EN
    logic              overflow_q, overflow_d;
    logic              zero_q, zero_d;
`endif

    logic [3:0] slice_x;
    logic [3:0] slice_y;
    logic [3:0] slice_s;
    logic       slice_co;

    assign slice_x = opa_q[4*idx_q +: 4];
    assign slice_y = opb_q[4*idx_q +: 4];

    cla_4 u_slice (
        .x    (slice_x),
        .y    (slice_y),
        .cin  (carry_q),
        .s    (slice_s),
        .cout (slice_co)
    );

    always_comb begin
        state_d  = state_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        result_d = result_q;
        carry_d  = carry_q;
        cout_d   = cout_q;
        idx_d    = idx_q;
`ifdef CLA_SEQ_FLAGS_EN
        overflow_d = overflow_q;
        zero_d     = zero_q;
`endif
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    // Subtraction is a + ~b + 1; the +1 enters as the initial carry.
                    opa_d   = a;
                    opb_d   = sub ? ~b : b;
                    carry_d = sub;
                    idx_d   = '0;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                result_d[4*idx_q +: 4] = slice_s;
                carry_d                = slice_co;
                idx_d                  = idx_q + 1'b1;
                if (idx_q == LAST_IDX) begin
                    cout_d  = slice_co;
                    idx_d   = '0;
                    state_d = DONE;
`ifdef CLA_SEQ_FLAGS_EN
                    overflow_d = (opa_q[WIDTH-1] == opb_q[WIDTH-1])
                              && (slice_s[3] != opa_q[WIDTH-1]);
                    zero_d     = (result_d == '0);
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            opa_q    <= '0;
            opb_q    <= '0;
            result_q <= '0;
            carry_q  <= 1'b0;
            cout_q   <= 1'b0;
            idx_q    <= '0;
`ifdef CLA_SEQ_FLAGS_EN
            overflow_q <= 1'b0;
            zero_q     <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            result_q <= result_d;
            carry_q  <= carry_d;
            cout_q   <= cout_d;
            idx_q    <= idx_d;
`ifdef CLA_SEQ_FLAGS_EN
            overflow_q <= overflow_d;
            zero_q     <= zero_d;
`endif
        end
    end

    assign busy   = (state_q == RUN);
    assign ready  = ~busy;
    assign done   = (state_q == DONE);
    assign result = result_q;
    assign cout   = cout_q;
`ifdef CLA_SEQ_FLAGS_EN
    assign overflow = overflow_q;
    assign zero     = zero_q;
`endif
endmodule

// File: tb/tb_cla_seq_adder.sv
// Directed-vector bench for cla_seq_adder (WIDTH=32); flag checks are compiled in with CLA_SEQ_FLAGS_EN.
`timescale 1ns/1ps
module tb_cla_seq_adder;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        sub = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        ready, busy, done, cout;
    logic [31:0] result;
`ifdef CLA_SEQ_FLAGS_EN
    logic        overflow, zero;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    cla_seq_adder #(.WIDTH(32)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .sub      (sub),
        .a        (a),
        .b        (b),
        .ready    (ready),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .cout     (cout)
`ifdef CLA_SEQ_FLAGS_EN
        ,
        .overflow (overflow),
        .zero     (zero)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Counts edges until done is seen; returns -1 if the bound expires.
    task automatic wait_done(output int n);
        n = -1;
        for (int i = 1; i <= 30; i++) begin
            @(posedge clk); #1;
            if (done) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic launch(input logic [31:0] va, input logic [31:0] vb, input logic vs);
        a = va; b = vb; sub = vs; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic do_op(input string tag, input logic [31:0] va, input logic [31:0] vb,
                         input logic vs, input logic [31:0] exp_res, input logic exp_cout);
        int n;
        launch(va, vb, vs);
        check({tag, "_busy"}, 32'(busy), 32'd1);
        wait_done(n);
        check({tag, "_lat"}, 32'(n), 32'd8);
        check({tag, "_res"}, result, exp_res);
        check({tag, "_cout"}, 32'(cout), 32'(exp_cout));
    endtask

    initial begin
        int n;
        int pulses;
        int done_at;

        #12;
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_result", result, 32'h0);
        check("rst_cout", 32'(cout), 32'd0);
`ifdef CLA_SEQ_FLAGS_EN
        check("rst_ovf", 32'(overflow), 32'd0);
        check("rst_zero", 32'(zero), 32'd0);
`endif
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        do_op("carry", 32'hFFFF_FFFF, 32'h1, 1'b0, 32'h0, 1'b1);
`ifdef CLA_SEQ_FLAGS_EN
        check("carry_zero", 32'(zero), 32'd1);
        check("carry_ovf", 32'(overflow), 32'd0);
`endif
        check("done_ready", 32'(ready), 32'd1);
        @(posedge clk); #1;
        check("done_pulse_width", 32'(done), 32'd0);

        do_op("sub_borrow", 32'd5, 32'd7, 1'b1, 32'hFFFF_FFFE, 1'b0);
`ifdef CLA_SEQ_FLAGS_EN
        check("sub_borrow_ovf", 32'(overflow), 32'd0);
        check("sub_borrow_zero", 32'(zero), 32'd0);
`endif
        @(posedge clk); #1;
        do_op("sub_nobrw", 32'd7, 32'd5, 1'b1, 32'h2, 1'b1);
        @(posedge clk); #1;

        do_op("ovf_add", 32'h7FFF_FFFF, 32'h1, 1'b0, 32'h8000_0000, 1'b0);
`ifdef CLA_SEQ_FLAGS_EN
        check("ovf_add_flag", 32'(overflow), 32'd1);
`endif
        @(posedge clk); #1;
        do_op("ovf_sub", 32'h8000_0000, 32'h1, 1'b1, 32'h7FFF_FFFF, 1'b1);
`ifdef CLA_SEQ_FLAGS_EN
        check("ovf_sub_flag", 32'(overflow), 32'd1);
`endif
        @(posedge clk); #1;

        // Busy protection: extra start pulses sampled at RUN edges 2 and 5.
        launch(32'h1234_5678, 32'h1111_1111, 1'b0);
        check("busy_ready", 32'(ready), 32'd0);
        pulses = 0;
        done_at = 0;
        for (int i = 1; i <= 12; i++) begin
            if (i == 2 || i == 5) begin
                start = 1'b1; a = 32'hDEAD_BEEF; b = 32'h0BAD_F00D; sub = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            if (done) begin
                pulses++;
                done_at = i;
            end
        end
        start = 1'b0;
        check("busy_pulses", 32'(pulses), 32'd1);
        check("busy_done_at", 32'(done_at), 32'd8);
        check("busy_res", result, 32'h2345_6789);

        // Back-to-back: start issued in the DONE cycle.
        do_op("b2b_first", 32'h1, 32'h2, 1'b0, 32'h3, 1'b0);
        a = 32'h0000_000F; b = 32'h1; sub = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("b2b_busy", 32'(busy), 32'd1);
        wait_done(n);
        check("b2b_gap", 32'(n + 1), 32'd9);
        check("b2b_res", result, 32'h10);
        check("b2b_cout", 32'(cout), 32'd0);
        @(posedge clk); #1;

        // Reset mid-operation.
        launch(32'hFFFF_FFFF, 32'h1, 1'b0);
        repeat (3) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        #1;
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_done", 32'(done), 32'd0);
        check("arst_ready", 32'(ready), 32'd1);
        check("arst_result", result, 32'h0);
        check("arst_cout", 32'(cout), 32'd0);
        @(negedge clk); rst_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (done) pulses++;
        end
        check("arst_no_done", 32'(pulses), 32'd0);
        do_op("post_rst", 32'h3, 32'h4, 1'b0, 32'h7, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
